// File: rtl/pixel_occupancy_reader_pkg.sv
// ---------------------------------------------------------------------------
// pixel_occupancy_reader_pkg : frame geometry, probe size, state encoding
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package pixel_occupancy_reader_pkg;

   localparam int unsigned XSCREEN = 160;
   localparam int unsigned YSCREEN = 120;
   localparam int unsigned XDIM    = 10;
   localparam int unsigned YDIM    = 10;
   localparam logic [2:0]  BG      = 3'b000;
   localparam int unsigned ADDR_W  = 15;
   localparam int unsigned NPIX    = XSCREEN * YSCREEN;
   localparam int unsigned CNT_W   = 4;

   typedef enum logic [2:0] {
      ST_CLEAR = 3'd0,
      ST_IDLE  = 3'd1,
      ST_SCAN  = 3'd2,
      ST_WAIT  = 3'd3,
      ST_DONE  = 3'd4
   } state_t;

   // y*160 + x built from shifts, matching the drawing FSM's address arithmetic
   function automatic logic [ADDR_W-1:0] pix_addr(input logic [7:0] px, input logic [6:0] py);
      logic [ADDR_W-1:0] y_w;
      y_w = {8'b0, py};
      return (y_w << 7) + (y_w << 5) + {7'b0, px};
   endfunction

endpackage

`default_nettype wire

// File: rtl/pixel_occupancy_reader_if.sv
// ---------------------------------------------------------------------------
// pixel_occupancy_reader_if : plot snoop stream and probe handshake
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface pixel_occupancy_reader_if;

   logic       plot;
   logic [7:0] x;
   logic [6:0] y;
   logic [2:0] colour;
   logic       probe_start;
   logic [7:0] probe_x;
   logic [6:0] probe_y;
   logic       probe_busy;
   logic       probe_done;
   logic       probe_hit;
   logic       clr_busy;

   modport master (
      output plot, x, y, colour, probe_start, probe_x, probe_y,
      input  probe_busy, probe_done, probe_hit, clr_busy
   );

   modport slave (
      input  plot, x, y, colour, probe_start, probe_x, probe_y,
      output probe_busy, probe_done, probe_hit, clr_busy
   );

endinterface

`default_nettype wire

// File: rtl/pixel_occupancy_reader_occ_ram.sv
// ---------------------------------------------------------------------------
// occ_ram : simple dual-port 1-bit RAM, read-during-write returns old data
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module occ_ram
   import pixel_occupancy_reader_pkg::*;
#(
   parameter int unsigned DEPTH = NPIX,
   parameter int unsigned AW    = ADDR_W
) (
   input  logic          CLOCK_50,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  logic          wr_data,
   input  logic          rd_en,
   input  logic [AW-1:0] rd_addr,
   output logic          rd_data
);

   logic mem [DEPTH];
   logic rd_data_q;

   always_ff @(posedge CLOCK_50) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
      if (rd_en) begin
         rd_data_q <= mem[rd_addr];
      end
   end

   assign rd_data = rd_data_q;

endmodule

`default_nettype wire

// File: rtl/pixel_occupancy_reader.sv
// ---------------------------------------------------------------------------
// pixel_occupancy_reader : shadow occupancy bitmap with square collision probe
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module pixel_occupancy_reader
   import pixel_occupancy_reader_pkg::*;
(
   input  logic                     CLOCK_50,
   input  logic                     Resetn,
   pixel_occupancy_reader_if.slave  bus
);

   state_t             state_q, state_d;
   logic [ADDR_W-1:0]  clr_cnt_q, clr_cnt_d;
   logic [CNT_W-1:0]   cx_q, cx_d;
   logic [CNT_W-1:0]   cy_q, cy_d;
   logic [7:0]         px_q, px_d;
   logic [6:0]         py_q, py_d;
   logic               acc_q, acc_d;
   logic               rd_pend_q, rd_pend_d;
   logic               hit_q, hit_d;

   logic               wr_en;
   logic [ADDR_W-1:0]  wr_addr;
   logic               wr_data;
   logic               rd_en;
   logic [ADDR_W-1:0]  rd_addr;
   logic               rd_data;

   logic [8:0]         scan_x;
   logic [7:0]         scan_y;
   logic               off_screen;
   logic               snoop_ok;
   logic               rd_bit;

   // Extra top bit keeps probe coordinates past the screen edge from wrapping
   assign scan_x     = {1'b0, px_q} + {5'b0, cx_q};
   assign scan_y     = {1'b0, py_q} + {4'b0, cy_q};
   assign off_screen = (scan_x >= 9'(XSCREEN)) || (scan_y >= 8'(YSCREEN));
   assign rd_addr    = pix_addr(scan_x[7:0], scan_y[6:0]);
   assign snoop_ok   = bus.plot && (bus.x < 8'(XSCREEN)) && (bus.y < 7'(YSCREEN));
   assign rd_bit     = rd_pend_q & rd_data;

   always_comb begin
      wr_en   = 1'b0;
      wr_addr = pix_addr(bus.x, bus.y);
      wr_data = (bus.colour != BG);
      if (state_q == ST_CLEAR) begin
         wr_en   = 1'b1;
         wr_addr = clr_cnt_q;
         wr_data = 1'b0;
      end else if (snoop_ok) begin
         wr_en   = 1'b1;
      end
   end

   always_comb begin
      state_d   = state_q;
      clr_cnt_d = clr_cnt_q;
      cx_d      = cx_q;
      cy_d      = cy_q;
      px_d      = px_q;
      py_d      = py_q;
      acc_d     = acc_q;
      rd_pend_d = 1'b0;
      hit_d     = hit_q;
      rd_en     = 1'b0;
      case (state_q)
         ST_CLEAR: begin
            clr_cnt_d = clr_cnt_q + 1'b1;
            if (clr_cnt_q == ADDR_W'(NPIX - 1)) begin
               clr_cnt_d = '0;
               state_d   = ST_IDLE;
            end
         end
         ST_IDLE: begin
            if (bus.probe_start) begin
               px_d    = bus.probe_x;
               py_d    = bus.probe_y;
               cx_d    = '0;
               cy_d    = '0;
               acc_d   = 1'b0;
               state_d = ST_SCAN;
            end
         end
         ST_SCAN: begin
            // Data for the previous cycle's address lands now; off-screen needs no read
            acc_d = acc_q | rd_bit;
            if (off_screen) begin
               acc_d = 1'b1;
            end else begin
               rd_en     = 1'b1;
               rd_pend_d = 1'b1;
            end
            if (cx_q == CNT_W'(XDIM - 1)) begin
               cx_d = '0;
               if (cy_q == CNT_W'(YDIM - 1)) begin
                  state_d = ST_WAIT;
               end else begin
                  cy_d = cy_q + 1'b1;
               end
            end else begin
               cx_d = cx_q + 1'b1;
            end
         end
         ST_WAIT: begin
            hit_d   = acc_q | rd_bit;
            state_d = ST_DONE;
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_CLEAR;
         end
      endcase
   end

   always_ff @(posedge CLOCK_50) begin
      if (!Resetn) begin
         state_q   <= ST_CLEAR;
         clr_cnt_q <= '0;
         cx_q      <= '0;
         cy_q      <= '0;
         px_q      <= '0;
         py_q      <= '0;
         acc_q     <= 1'b0;
         rd_pend_q <= 1'b0;
         hit_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         clr_cnt_q <= clr_cnt_d;
         cx_q      <= cx_d;
         cy_q      <= cy_d;
         px_q      <= px_d;
         py_q      <= py_d;
         acc_q     <= acc_d;
         rd_pend_q <= rd_pend_d;
         hit_q     <= hit_d;
      end
   end

   occ_ram #(
      .DEPTH (NPIX),
      .AW    (ADDR_W)
   ) u_occ_ram (
      .CLOCK_50 (CLOCK_50),
      .wr_en    (wr_en),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .rd_en    (rd_en),
      .rd_addr  (rd_addr),
      .rd_data  (rd_data)
   );

   assign bus.probe_busy = (state_q != ST_IDLE);
   assign bus.probe_done = (state_q == ST_DONE);
   assign bus.probe_hit  = hit_q;
   assign bus.clr_busy   = (state_q == ST_CLEAR);

endmodule

`default_nettype wire

// File: tb/tb_pixel_occupancy_reader.sv
// ---------------------------------------------------------------------------
// tb_pixel_occupancy_reader : directed probes against a pixel-map model
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_pixel_occupancy_reader;
   import pixel_occupancy_reader_pkg::*;

   logic CLOCK_50 = 1'b0;
   logic Resetn   = 1'b0;

   pixel_occupancy_reader_if bus ();

   pixel_occupancy_reader dut (
      .CLOCK_50 (CLOCK_50),
      .Resetn   (Resetn),
      .bus      (bus)
   );

   always #10 CLOCK_50 = ~CLOCK_50;

   int n_tests = 0;
   int n_fail  = 0;

   // Model: a plain pixel array plus a phase/step description of a probe
   localparam int P_CLEAR = 0;
   localparam int P_IDLE  = 1;
   localparam int P_PROBE = 2;
   localparam int P_DONE  = 3;

   bit m_mem [NPIX];
   int m_phase = P_CLEAR;
   int m_prev;
   int m_clr;
   int m_k;
   int m_px, m_py, m_sx, m_sy;
   bit m_acc;
   bit m_hit   = 1'b0;
   bit m_valid = 1'b0;

   task automatic check(input string name, input logic act, input logic exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0b, expected %0b", name, $time, act, exp);
      end
   endtask

   task automatic check_int(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
      end
   endtask

   initial begin : model
      forever begin
         @(posedge CLOCK_50);
         m_prev = m_phase;
         if (!Resetn) begin
            m_phase = P_CLEAR;
            m_clr   = 0;
            m_hit   = 1'b0;
            m_valid = 1'b1;
         end else begin
            case (m_phase)
               P_CLEAR: begin
                  m_clr++;
                  if (m_clr == NPIX) begin
                     foreach (m_mem[i]) m_mem[i] = 1'b0;
                     m_phase = P_IDLE;
                  end
               end
               P_IDLE: begin
                  if (bus.probe_start) begin
                     m_px    = int'(bus.probe_x);
                     m_py    = int'(bus.probe_y);
                     m_k     = 0;
                     m_acc   = 1'b0;
                     m_phase = P_PROBE;
                  end
               end
               P_PROBE: begin
                  if (m_k < XDIM * YDIM) begin
                     m_sx = m_px + (m_k % XDIM);
                     m_sy = m_py + (m_k / XDIM);
                     if (m_sx >= XSCREEN || m_sy >= YSCREEN) m_acc = 1'b1;
                     else if (m_mem[m_sy * XSCREEN + m_sx]) m_acc = 1'b1;
                     m_k++;
                  end else begin
                     m_hit   = m_acc;
                     m_phase = P_DONE;
                  end
               end
               default: m_phase = P_IDLE;
            endcase
         end
         // Reads above see the array before this edge's write
         if (m_prev != P_CLEAR && bus.plot && bus.x < XSCREEN && bus.y < YSCREEN)
            m_mem[int'(bus.y) * XSCREEN + int'(bus.x)] = (bus.colour != 3'b000);
      end
   end

   initial begin : compare
      forever begin
         @(negedge CLOCK_50);
         if (m_valid) begin
            check("probe_busy", bus.probe_busy, m_phase != P_IDLE);
            check("probe_done", bus.probe_done, m_phase == P_DONE);
            check("probe_hit",  bus.probe_hit,  m_hit);
            check("clr_busy",   bus.clr_busy,   m_phase == P_CLEAR);
         end
      end
   end

   task automatic plot_px(input logic [7:0] px, input logic [6:0] py, input logic [2:0] col);
      bus.plot   = 1'b1;
      bus.x      = px;
      bus.y      = py;
      bus.colour = col;
      @(negedge CLOCK_50);
      bus.plot   = 1'b0;
   endtask

   task automatic wait_clear(input string name);
      int n;
      n = 0;
      while (bus.clr_busy && n < 20000) begin
         n++;
         @(negedge CLOCK_50);
      end
      check_int(name, n, 19200);
   endtask

   // Cycle t+1 begins at the start-sampling edge t, so done observed j edges later is cycle t+j+1
   task automatic run_probe(input string name, input logic [7:0] px, input logic [6:0] py,
                            input logic exp_hit, input int plot_k, input int restart_k);
      int ndone;
      int lat;
      ndone = 0;
      lat   = -1;
      bus.probe_start = 1'b1;
      bus.probe_x     = px;
      bus.probe_y     = py;
      @(posedge CLOCK_50);
      for (int j = 0; j < 130; j++) begin
         @(negedge CLOCK_50);
         bus.probe_start = (j == restart_k);
         bus.probe_x     = 8'd0;
         bus.probe_y     = 7'd0;
         bus.plot        = (j == plot_k);
         if (j == plot_k) begin
            bus.x      = px + 8'(plot_k % XDIM);
            bus.y      = py + 7'(plot_k / XDIM);
            bus.colour = 3'b001;
         end
         if (bus.probe_done) begin
            ndone++;
            if (lat < 0) lat = j + 1;
         end
      end
      bus.probe_start = 1'b0;
      bus.plot        = 1'b0;
      check_int({name, "_latency"}, lat, 102);
      check_int({name, "_done_count"}, ndone, 1);
      check({name, "_hit"}, bus.probe_hit, exp_hit);
   endtask

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin : stim
      bus.plot        = 1'b0;
      bus.x           = 8'd0;
      bus.y           = 7'd0;
      bus.colour      = 3'b000;
      bus.probe_start = 1'b0;
      bus.probe_x     = 8'd0;
      bus.probe_y     = 7'd0;
      Resetn          = 1'b0;
      repeat (3) @(negedge CLOCK_50);
      check("reset_probe_busy", bus.probe_busy, 1'b1);
      check("reset_clr_busy",   bus.clr_busy,   1'b1);
      check("reset_probe_done", bus.probe_done, 1'b0);
      check("reset_probe_hit",  bus.probe_hit,  1'b0);
      Resetn = 1'b1;
      wait_clear("clear_len");
      @(negedge CLOCK_50);

      run_probe("empty_origin", 8'd0, 7'd0, 1'b0, -1, -1);

      plot_px(8'd45, 7'd30, 3'b010);
      run_probe("drawn_hit",  8'd40, 7'd25, 1'b1, -1, -1);
      run_probe("drawn_miss", 8'd60, 7'd25, 1'b0, -1, -1);

      plot_px(8'd45, 7'd30, BG);
      run_probe("erased", 8'd40, 7'd25, 1'b0, -1, -1);

      run_probe("right_edge", 8'd155, 7'd50,  1'b1, -1, -1);
      run_probe("corner_in",  8'd150, 7'd110, 1'b0, -1, -1);

      plot_px(8'd200, 7'd10, 3'b001);
      run_probe("oob_plot_dropped", 8'd35, 7'd6, 1'b0, -1, -1);

      run_probe("rdw_old", 8'd95, 7'd55, 1'b0, 55, 20);
      run_probe("rdw_new", 8'd95, 7'd55, 1'b1, -1, -1);

      plot_px(8'd10, 7'd10, 3'b111);
      bus.probe_start = 1'b1;
      bus.probe_x     = 8'd0;
      bus.probe_y     = 7'd0;
      @(negedge CLOCK_50);
      bus.probe_start = 1'b0;
      repeat (40) @(negedge CLOCK_50);
      Resetn = 1'b0;
      @(negedge CLOCK_50);
      check("midscan_clr_busy",   bus.clr_busy,   1'b1);
      check("midscan_probe_done", bus.probe_done, 1'b0);
      check("midscan_probe_hit",  bus.probe_hit,  1'b0);
      Resetn = 1'b1;
      wait_clear("clear_len_again");
      @(negedge CLOCK_50);

      run_probe("cleared_a", 8'd95, 7'd55, 1'b0, -1, -1);
      run_probe("cleared_b", 8'd5,  7'd5,  1'b0, -1, -1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/pixel_occupancy_reader.md
# pixel_occupancy_reader

Shadow bitmap of the 160x120 frame buffer. It snoops the same plot stream (plot, x, y, colour) that the drawing FSM sends to vga_adapter and records one bit per pixel: set when the pixel is drawn in a non-background colour, cleared when it is erased. A probe FSM reads the bitmap back over an XDIM x YDIM square so the game logic can test the next snake-head position for collision before moving.

## Interface
- XSCREEN, 160, screen width in pixels
- YSCREEN, 120, screen height in pixels
- XDIM, 10, probe square width
- YDIM, 10, probe square height
- BG, 3'b000, background/erase colour

- CLOCK_50  in  1  system clock
- Resetn  in  1  reset, synchronous, active-low
- plot  in  1  pixel-write strobe, same cycle as x/y/colour
- x  in  8  pixel column
- y  in  7  pixel row
- colour  in  3  pixel colour
- probe_start  in  1  one-cycle request; sampled only in IDLE
- probe_x  in  8  probe square top-left column, sampled with probe_start
- probe_y  in  7  probe square top-left row, sampled with probe_start
- probe_busy  out  1  high in CLEAR, SCAN, WAIT, DONE
- probe_done  out  1  one-cycle pulse; probe_hit valid
- probe_hit  out  1  1 if any probed pixel is occupied or off-screen; held until next accepted start
- clr_busy  out  1  high while the bitmap is being cleared

## Operation
- States: CLEAR, IDLE, SCAN, WAIT, DONE.
- CLEAR is entered on reset, including reset mid-scan. It writes 0 to addresses 0..XSCREEN*YSCREEN-1, one per cycle, and takes 19200 cycles. Last address -> IDLE.
- Address is y*XSCREEN + x, 15 bits, computed as (y<<7)+(y<<5)+x for 160.
- Snoop write, any state except CLEAR: plot=1, x<XSCREEN and y<YSCREEN -> mem[addr] <= (colour != BG).
  - Out-of-range writes are dropped.
  - Writes during CLEAR are dropped.
- IDLE: probe_start=1 latches probe_x/probe_y, clears the hit accumulator, and goes to SCAN. Otherwise stays in IDLE.
- SCAN issues one read per cycle, raster order: column offset 0..XDIM-1 inner, row offset 0..YDIM-1 outer. That is exactly XDIM*YDIM reads, with no early exit.
- Off-screen pixels (probe_x+cx >= XSCREEN or probe_y+cy >= YSCREEN, computed at 9/8-bit width with no wrap) force hit=1. The RAM read for such a pixel is suppressed.
- After the last read, go to WAIT (captures the final read data), then DONE. DONE -> IDLE after 1 cycle.
- probe_start outside IDLE is ignored. It is not queued.
- Simultaneous snoop write and probe read of the same address: the read returns the old data.

## Timing
- Reset values: probe_busy=1, clr_busy=1, probe_done=0, probe_hit=0, state=CLEAR.
- Memory has 1-cycle read latency. Read data is OR'd into the accumulator the cycle after the address is issued.
- probe_start sampled at edge t -> SCAN during cycles t+1..t+XDIM*YDIM -> WAIT -> probe_done high in cycle t+XDIM*YDIM+2 (t+102 by default).
- probe_hit updates at the edge entering DONE and holds until the next accepted start.
- probe_busy falls the cycle after DONE. A new probe_start can be accepted in that first IDLE cycle.
- Snoop write takes effect at the next edge. A probe started the cycle after a write sees it.

## Structure
- Shared package holds XSCREEN, YSCREEN, XDIM, YDIM, BG, the state encoding, and the address-width constant (15). The drawing FSM and this block share the same values.
- One sub-module, occ_ram: simple dual-port 19200x1 RAM.
  - One synchronous write port and one synchronous read port.
  - Read-during-write returns old data.
  - Inferred as block RAM.
- Address mux (clear counter vs snoop address), probe counters (cx 4-bit, cy 4-bit) and the FSM live in the top.

## Test plan
- Reset, then count cycles: clr_busy stays high exactly 19200 cycles, then IDLE. A probe at (0,0) then returns done with hit=0 at start+102.
- plot=1 at (45,30) colour 3'b010; probe (40,25) -> hit=1. Probe (60,25) -> hit=0.
- Draw (45,30), then erase it with colour=BG; probe (40,25) -> hit=0.
- Probe (155,50): columns 160..164 are off-screen -> hit=1. Probe (150,110) fully on-screen and empty -> hit=0.
- probe_start re-asserted during SCAN is ignored, with exactly one done pulse. Plot (100,60) in the same cycle the probe's read of (100,60) is issued: that probe returns the old value 0, and the next probe returns 1.
- Resetn low mid-SCAN -> next cycle CLEAR with probe_hit=0 and probe_done=0. After the 19200-cycle clear, previously drawn pixels probe as 0.
